// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: each accepted word goes out as SYNC_PAT, the payload MSB-first,
// then GAP_BITS zero bits, one bit per clk on tx_bit.
module seq_frame_tx #(
   parameter int                DATA_W   = 8,
   parameter int                SYNC_W   = 4,
   parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1001,
   parameter int                GAP_BITS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              tx_bit,
   output logic              tx_en,
   output logic              frame_done
);

   localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
   localparam int MAX_LEN = (MAX_SD > GAP_BITS) ? MAX_SD : GAP_BITS;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);
   localparam int SH_W    = SYNC_W + DATA_W;

   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);

   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_SYNC = 4'b0010,
      S_DATA = 4'b0100,
      S_GAP  = 4'b1000
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [SH_W-1:0]   r_shift;
   logic [SH_W-1:0]   w_shift_next;
   logic              r_tx_bit;
   logic              r_tx_en;
   logic              r_frame_done;
   logic              w_tx_bit_next;
   logic              w_tx_en_next;
   logic              w_done_next;
   logic              w_ready;
   logic              w_accept;

   // The state register runs one cycle ahead of the registered line outputs,
   // which gives the one-cycle accept-to-first-bit latency.
   assign w_ready  = (r_state == S_IDLE) || ((r_state == S_GAP) && (r_cnt == GAP_LAST));
   assign w_accept = in_valid && w_ready;

   assign in_ready   = w_ready;
   assign tx_bit     = r_tx_bit;
   assign tx_en      = r_tx_en;
   assign frame_done = r_frame_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_shift      <= '0;
         r_tx_bit     <= 1'b0;
         r_tx_en      <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_shift      <= w_shift_next;
         r_tx_bit     <= w_tx_bit_next;
         r_tx_en      <= w_tx_en_next;
         r_frame_done <= w_done_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_shift_next  = r_shift;
      w_tx_bit_next = 1'b0;
      w_tx_en_next  = 1'b0;
      w_done_next   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = S_SYNC;
               w_cnt_next   = '0;
               w_shift_next = {SYNC_PAT, in_data};
            end
         end
         // Sync pattern and payload share one shift register, emitted from its MSB.
         S_SYNC: begin
            w_tx_bit_next = r_shift[SH_W-1];
            w_tx_en_next  = 1'b1;
            w_shift_next  = {r_shift[SH_W-2:0], 1'b0};
            if (r_cnt == SYNC_LAST) begin
               w_state_next = S_DATA;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         S_DATA: begin
            w_tx_bit_next = r_shift[SH_W-1];
            w_tx_en_next  = 1'b1;
            w_shift_next  = {r_shift[SH_W-2:0], 1'b0};
            if (r_cnt == DATA_LAST) begin
               w_state_next = S_GAP;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         S_GAP: begin
            w_tx_en_next = 1'b1;
            if (r_cnt == GAP_LAST) begin
               w_done_next = 1'b1;
               w_cnt_next  = '0;
               if (w_accept) begin
                  w_state_next = S_SYNC;
                  w_shift_next = {SYNC_PAT, in_data};
               end else begin
                  w_state_next = S_IDLE;
               end
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_shift_next = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: a queue-based timeline model of the serial line predicts every
// output cycle; directed scenarios plus a randomized run and a 1001-detector loopback.
module tb_seq_frame_tx;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data  = 8'h00;
   logic       in_ready;
   logic       tx_bit;
   logic       tx_en;
   logic       frame_done;

   always #5 clk = ~clk;

   seq_frame_tx dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .tx_bit     (tx_bit),
      .tx_en      (tx_en),
      .frame_done (frame_done)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model: queue of {bit, en, done} for upcoming output cycles; one entry consumed per edge.
   logic [2:0] q[$];
   logic [2:0] exp_out   = 3'b000;
   logic       exp_ready = 1'b1;
   logic       obs_ready = 1'b0;

   // Downstream 1001 detector (Mealy output on the current line bit).
   logic [3:0] det_hist = 4'b0000;
   logic       det_z;
   assign det_z = ({det_hist[2:0], tx_bit} == 4'b1001);
   always @(posedge clk) det_hist <= {det_hist[2:0], tx_bit};

   function automatic logic [13:0] frame_bits(input logic [7:0] d);
      return {4'b1001, d, 2'b00};
   endfunction

   // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
   task automatic step(input logic v, input logic [7:0] d);
      logic [13:0] f;
      in_valid  = v;
      in_data   = d;
      exp_ready = (q.size() <= 1);
      #1;
      obs_ready = in_ready;
      @(posedge clk);
      if (q.size() > 0) exp_out = q.pop_front();
      else              exp_out = 3'b000;
      if (v && exp_ready) begin
         f = frame_bits(d);
         for (int i = 13; i >= 0; i--) q.push_back({f[i], 1'b1, (i == 0)});
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({tx_bit, tx_en, frame_done, in_ready} !== 4'b0001)
         $display("FAIL reset_poweron got %b want 0001", {tx_bit, tx_en, frame_done, in_ready});
      else n_pass++;
      rst_n = 1'b1;
      step(1'b1, 8'($urandom));
      for (int i = 0; i < 6; i++) step(1'b0, 8'($urandom));
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      n_checks++;
      if ({tx_bit, tx_en, frame_done, in_ready} !== 4'b0001)
         $display("FAIL reset_async got %b want 0001", {tx_bit, tx_en, frame_done, in_ready});
      else n_pass++;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({tx_bit, tx_en, frame_done, in_ready} !== 4'b0001)
            $display("FAIL reset_hold cyc%0d got %b want 0001", i, {tx_bit, tx_en, frame_done, in_ready});
         else n_pass++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 8'h00);
         n_checks++;
         if ({tx_bit, tx_en, frame_done, obs_ready} !== {exp_out, exp_ready})
            $display("FAIL reset_release cyc%0d got %b want %b", i, {tx_bit, tx_en, frame_done, obs_ready}, {exp_out, exp_ready});
         else n_pass++;
      end
   endtask

   task automatic test_single_frame();
      logic [13:0] got;
      logic [13:0] want;
      want = 14'b1001_10100101_00;
      got  = '0;
      for (int i = 0; i <= 15; i++) begin
         step(i == 0, (i == 0) ? 8'hA5 : 8'($urandom));
         n_checks++;
         if ({tx_bit, tx_en, frame_done, obs_ready} !== {exp_out, exp_ready})
            $display("FAIL single cyc%0d got %b want %b", i, {tx_bit, tx_en, frame_done, obs_ready}, {exp_out, exp_ready});
         else n_pass++;
         if (i >= 1 && i <= 14) got[14-i] = tx_bit;
      end
      n_checks++;
      if (got !== want) $display("FAIL single_stream got %b want %b", got, want);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [27:0] got;
      logic [27:0] want;
      want = 28'b1001_11111111_00_1001_00000000_00;
      got  = '0;
      for (int i = 0; i <= 29; i++) begin
         step(i <= 14, (i < 14) ? 8'hFF : 8'h00);
         n_checks++;
         if ({tx_bit, tx_en, frame_done, obs_ready} !== {exp_out, exp_ready})
            $display("FAIL b2b cyc%0d got %b want %b", i, {tx_bit, tx_en, frame_done, obs_ready}, {exp_out, exp_ready});
         else n_pass++;
         if (i >= 1 && i <= 28) got[28-i] = tx_bit;
      end
      n_checks++;
      if (got !== want) $display("FAIL b2b_stream got %b want %b", got, want);
      else n_pass++;
   endtask

   task automatic test_busy_ignore();
      for (int i = 0; i <= 19; i++) begin
         if (i == 0)      step(1'b1, 8'h5A);
         else if (i == 7) step(1'b1, 8'h3C);
         else             step(1'b0, 8'($urandom));
         n_checks++;
         if ({tx_bit, tx_en, frame_done, obs_ready} !== {exp_out, exp_ready})
            $display("FAIL busy cyc%0d got %b want %b", i, {tx_bit, tx_en, frame_done, obs_ready}, {exp_out, exp_ready});
         else n_pass++;
         if (i == 7) begin
            n_checks++;
            if (obs_ready !== 1'b0) $display("FAIL busy_ready got %b want 0", obs_ready);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_data();
      logic [13:0] got;
      logic [13:0] want;
      want = 14'b1001_10000001_00;
      got  = '0;
      for (int i = 0; i <= 8; i++) step(i == 0, 8'($urandom));
      n_checks++;
      if (tx_en !== 1'b1) $display("FAIL middata_pre tx_en got %b want 1", tx_en);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      n_checks++;
      if ({tx_bit, tx_en, frame_done, in_ready} !== 4'b0001)
         $display("FAIL middata_rst got %b want 0001", {tx_bit, tx_en, frame_done, in_ready});
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i <= 15; i++) begin
         step(i == 0, (i == 0) ? 8'h81 : 8'($urandom));
         n_checks++;
         if ({tx_bit, tx_en, frame_done, obs_ready} !== {exp_out, exp_ready})
            $display("FAIL middata cyc%0d got %b want %b", i, {tx_bit, tx_en, frame_done, obs_ready}, {exp_out, exp_ready});
         else n_pass++;
         if (i >= 1 && i <= 14) got[14-i] = tx_bit;
      end
      n_checks++;
      if (got !== want) $display("FAIL middata_stream got %b want %b", got, want);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 8'($urandom));
         n_checks++;
         if ({tx_bit, tx_en, frame_done, obs_ready} !== {exp_out, exp_ready})
            $display("FAIL random cyc%0d got %b want %b", i, {tx_bit, tx_en, frame_done, obs_ready}, {exp_out, exp_ready});
         else n_pass++;
      end
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00);
   endtask

   task automatic test_loopback();
      for (int i = 0; i <= 29; i++) begin
         step(i <= 14, (i < 14) ? 8'h12 : 8'h00);
         n_checks++;
         if ({tx_bit, tx_en, frame_done, obs_ready} !== {exp_out, exp_ready})
            $display("FAIL loop cyc%0d got %b want %b", i, {tx_bit, tx_en, frame_done, obs_ready}, {exp_out, exp_ready});
         else n_pass++;
         if (i == 4 || i == 18) begin
            n_checks++;
            if (det_z !== 1'b1) $display("FAIL loop_sync cyc%0d z got %b want 1", i, det_z);
            else n_pass++;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid_data();
      test_random();
      test_loopback();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
